imem_loader: RTL

Program loader that writes the PA-RISC PPU's byte-wide, big-endian instruction memory. It accepts 32-bit instruction words over a valid/ready stream and serializes each word into four byte writes at consecutive addresses, MSB first. It holds the PPU in reset (`cpu_hold`) until the final word has landed. It sits between the test/boot source and the write port of the 256×8 instruction store.

---
 rtl/imem_loader_pkg.sv | 28 ++
 rtl/word_byte_serializer.sv | 39 +++
 rtl/imem_loader.sv | 111 +++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared constants for the PPU instruction store: geometry, loader states and
// the big-endian byte selection used when serializing instruction words.
package imem_loader_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned IMEM_ADDR_W    = 8;
  localparam int unsigned IMEM_DEPTH     = 256;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WRITE,
    ST_DONE,
    ST_ERR
  } loader_state_e;

  function automatic logic [7:0] be_byte(input logic [31:0] word, input logic [1:0] idx);
    logic [7:0] b;
    unique case (idx)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/word_byte_serializer.sv
// Latches one instruction word and presents its bytes MSB first, one per
// advance, from a registered byte output.
module word_byte_serializer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        advance,
  input  logic [31:0] data_in,
  output logic [7:0]  byte_out,
  output logic        last_byte
);

  logic [31:0] word;
  logic [1:0]  idx;
  logic [1:0]  idx_next;

  assign idx_next  = idx + 2'd1;
  assign last_byte = (idx == 2'(BYTES_PER_WORD - 1));

  // byte_out is loaded with the byte for the index being entered so the
  // write data is valid in the same cycle as the strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word     <= '0;
      idx      <= '0;
      byte_out <= '0;
    end else if (load) begin
      word     <= data_in;
      idx      <= '0;
      byte_out <= be_byte(data_in, 2'd0);
    end else if (advance) begin
      idx      <= idx_next;
      byte_out <= be_byte(word, idx_next);
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: accepts 32-bit words on a valid/ready stream and writes them
// big-endian into the byte-wide instruction store, holding the PPU in reset.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned MAX_WORDS = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   word_valid,
  input  logic [31:0]            word_data,
  input  logic                   word_last,
  output logic                   word_ready,
  output logic                   mem_we,
  output logic [IMEM_ADDR_W-1:0] mem_addr,
  output logic [7:0]             mem_wdata,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic                   cpu_hold,
  output logic [6:0]             word_count
);

  localparam logic [IMEM_ADDR_W-1:0] BASE    = IMEM_ADDR_W'(BASE_ADDR);
  localparam logic [6:0]             MAX_CNT = 7'(MAX_WORDS);

  loader_state_e          state, state_next;
  logic [IMEM_ADDR_W-1:0] ptr, ptr_next, addr_next;
  logic [6:0]             count_next;
  logic                   last_q;
  logic                   load, advance, last_byte;

  word_byte_serializer u_ser (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .advance   (advance),
    .data_in   (word_data),
    .byte_out  (mem_wdata),
    .last_byte (last_byte)
  );

  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    addr_next  = mem_addr;
    count_next = word_count;
    load       = 1'b0;
    advance    = 1'b0;
    unique case (state)
      ST_LOAD: begin
        if (word_valid) begin
          load       = 1'b1;
          addr_next  = ptr;
          state_next = ST_WRITE;
        end
      end
      ST_WRITE: begin
        advance   = 1'b1;
        ptr_next  = ptr + IMEM_ADDR_W'(1);
        addr_next = ptr + IMEM_ADDR_W'(1);
        if (last_byte) begin
          count_next = word_count + 7'd1;
          if (last_q)                     state_next = ST_DONE;
          else if (count_next == MAX_CNT) state_next = ST_ERR;
          else                            state_next = ST_LOAD;
        end
      end
      default: begin
        if (start) begin
          state_next = ST_LOAD;
          ptr_next   = BASE;
          count_next = '0;
        end
      end
    endcase
  end

  // Status outputs are registered from the next state so they line up with
  // the state they describe and never see an input combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      ptr        <= BASE;
      mem_addr   <= '0;
      word_count <= '0;
      last_q     <= 1'b0;
      word_ready <= 1'b0;
      mem_we     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      cpu_hold   <= 1'b1;
    end else begin
      state      <= state_next;
      ptr        <= ptr_next;
      mem_addr   <= addr_next;
      word_count <= count_next;
      if (load) last_q <= word_last;
      word_ready <= (state_next == ST_LOAD);
      mem_we     <= (state_next == ST_WRITE);
      busy       <= (state_next == ST_LOAD) || (state_next == ST_WRITE);
      done       <= (state_next == ST_DONE);
      error      <= (state_next == ST_ERR);
      cpu_hold   <= (state_next != ST_DONE);
    end
  end

endmodule
